// File: rtl/bank_stats_pkg.sv
// Shared widths, outstanding-table entry layout and saturating helpers for the
// per-bank request latency tracker.
package bank_stats_pkg;

    localparam int CYCLE_W = 64;
    localparam int ID_W    = 32;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic               isWrite;
        logic [CYCLE_W-1:0] issueCycle;
    } lat_entry_t;

    // Counters narrower than 64 bits are passed zero-extended; width sets the ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] maxVal;
        maxVal = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= maxVal) ? maxVal : value + 64'd1;
    endfunction

endpackage

// File: rtl/bank_stats_lowest_one.sv
// Priority encoder: index of the lowest set bit of i_vec plus a found flag.
// Used for both free-slot selection and CAM match selection in the tracker.
module bank_stats_lowest_one #(
    parameter int N = 16
) (
    input  logic [N-1:0]         i_vec,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int IDX_W = $clog2(N);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_scheduler_request_latency_tracker.sv
// Passive monitor matching requests to responses for one (RANK,BANK) scheduler.
// Define BANK_STATS_CSV_LOG_EN to add simulation-only CSV logging of completions and drops.
module bank_scheduler_request_latency_tracker
    import bank_stats_pkg::*;
#(
    parameter int RANK  = 0,
    parameter int BANK  = 0,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CYCLE_W-1:0]       globalCycle,
    input  logic                     req_fire,
    input  logic [ID_W-1:0]          req_request_id,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     req_is_write,
    input  logic                     resp_fire,
    input  logic [ID_W-1:0]          resp_request_id,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     table_full,
    output logic                     lat_valid,
    output logic [CYCLE_W-1:0]       lat_last,
    output logic [ID_W-1:0]          id_last,
    output logic [CYCLE_W-1:0]       lat_min,
    output logic [CYCLE_W-1:0]       lat_max,
    output logic [CYCLE_W-1:0]       lat_sum,
    output logic [CNT_W-1:0]         completed,
    output logic [CNT_W-1:0]         dropped_reqs,
    output logic [CNT_W-1:0]         orphan_resps
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    lat_entry_t         r_table [DEPTH];
    logic               r_latValid;
    logic [CYCLE_W-1:0] r_latLast;
    logic [ID_W-1:0]    r_idLast;
    logic [CYCLE_W-1:0] r_latMin;
    logic [CYCLE_W-1:0] r_latMax;
    logic [CYCLE_W-1:0] r_latSum;
    logic [CNT_W-1:0]   r_completed;
    logic [CNT_W-1:0]   r_dropped;
    logic [CNT_W-1:0]   r_orphan;

    logic [DEPTH-1:0]   w_freeVec;
    logic [DEPTH-1:0]   w_matchVec;
    logic [IDX_W-1:0]   w_freeIdx;
    logic [IDX_W-1:0]   w_matchIdx;
    logic               w_freeFound;
    logic               w_matchFound;
    logic [CYCLE_W-1:0] w_latency;
    logic [CYCLE_W:0]   w_sumExt;
    logic [OCC_W-1:0]   w_outstanding;

    // Both selections look only at start-of-cycle state, so a slot freed by a
    // response is never handed to a same-cycle request.
    always_comb begin
        w_freeVec  = '0;
        w_matchVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_freeVec[i]  = ~r_table[i].valid;
            w_matchVec[i] = r_table[i].valid && (r_table[i].id == resp_request_id);
        end
    end

    bank_stats_lowest_one #(.N(DEPTH)) u_freeSelect (
        .i_vec   (w_freeVec),
        .o_idx   (w_freeIdx),
        .o_found (w_freeFound)
    );

    bank_stats_lowest_one #(.N(DEPTH)) u_matchSelect (
        .i_vec   (w_matchVec),
        .o_idx   (w_matchIdx),
        .o_found (w_matchFound)
    );

    assign w_latency = globalCycle - r_table[w_matchIdx].issueCycle;
    assign w_sumExt  = {1'b0, r_latSum} + {1'b0, w_latency};

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
            r_latValid  <= 1'b0;
            r_latLast   <= '0;
            r_idLast    <= '0;
            r_latMin    <= '1;
            r_latMax    <= '0;
            r_latSum    <= '0;
            r_completed <= '0;
            r_dropped   <= '0;
            r_orphan    <= '0;
        end else begin
            r_latValid <= 1'b0;
            if (resp_fire) begin
                if (w_matchFound) begin
                    r_table[w_matchIdx].valid <= 1'b0;
                    r_latValid  <= 1'b1;
                    r_latLast   <= w_latency;
                    r_idLast    <= resp_request_id;
                    r_completed <= CNT_W'(sat_inc(64'(r_completed), CNT_W));
                    if (w_latency < r_latMin) begin
                        r_latMin <= w_latency;
                    end
                    if (w_latency > r_latMax) begin
                        r_latMax <= w_latency;
                    end
                    r_latSum <= w_sumExt[CYCLE_W] ? '1 : w_sumExt[CYCLE_W-1:0];
                end else begin
                    r_orphan <= CNT_W'(sat_inc(64'(r_orphan), CNT_W));
                end
            end
            if (req_fire) begin
                if (w_freeFound) begin
                    r_table[w_freeIdx] <= '{valid:      1'b1,
                                            id:         req_request_id,
                                            addr:       req_addr,
                                            isWrite:    req_is_write,
                                            issueCycle: globalCycle};
                end else begin
                    r_dropped <= CNT_W'(sat_inc(64'(r_dropped), CNT_W));
                end
            end
        end
    end

    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_outstanding = w_outstanding + OCC_W'(r_table[i].valid);
        end
    end

    assign outstanding  = w_outstanding;
    assign table_full   = (w_outstanding == OCC_W'(DEPTH));
    assign lat_valid    = r_latValid;
    assign lat_last     = r_latLast;
    assign id_last      = r_idLast;
    assign lat_min      = r_latMin;
    assign lat_max      = r_latMax;
    assign lat_sum      = r_latSum;
    assign completed    = r_completed;
    assign dropped_reqs = r_dropped;
    assign orphan_resps = r_orphan;

`ifdef BANK_STATS_CSV_LOG_EN
    // Emits the CSV header once, tagged with the instance's rank and bank.
    initial begin
        $display("memory_request_latency_stats_rank%0d_bank%0d: RequestID,Address,IsWrite,IssueCycle,Latency", RANK, BANK);
    end

    // Emits one CSV line per matched response and one DROP line per dropped request.
    always @(posedge clk) begin
        if (reset) begin
            if (resp_fire && w_matchFound) begin
                $display("%0d,%0d,%0d,%0d,%0d", resp_request_id,
                         r_table[w_matchIdx].addr, r_table[w_matchIdx].isWrite,
                         r_table[w_matchIdx].issueCycle, w_latency);
            end
            if (req_fire && !w_freeFound) begin
                $display("DROP,%0d,%0d", req_request_id, globalCycle);
            end
        end
    end
`else
    // Address, direction and instance indices only feed the CSV log; fold them into a sink.
    logic w_unusedCsvFields;

    always_comb begin
        w_unusedCsvFields = (^32'(RANK)) ^ (^32'(BANK));
        for (int i = 0; i < DEPTH; i++) begin
            w_unusedCsvFields = w_unusedCsvFields ^ (^r_table[i].addr) ^ r_table[i].isWrite;
        end
    end
`endif

endmodule

// File: tb/tb_bank_scheduler_request_latency_tracker.sv
// Self-checking bench for bank_scheduler_request_latency_tracker: directed scenarios
// plus randomized traffic compared against a slot-table reference model.
module tb_bank_scheduler_request_latency_tracker;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] globalCycle;
    logic        req_fire;
    logic [31:0] req_request_id;
    logic [31:0] req_addr;
    logic        req_is_write;
    logic        resp_fire;
    logic [31:0] resp_request_id;
    logic [4:0]  outstanding;
    logic        table_full;
    logic        lat_valid;
    logic [63:0] lat_last;
    logic [31:0] id_last;
    logic [63:0] lat_min;
    logic [63:0] lat_max;
    logic [63:0] lat_sum;
    logic [CNT_W-1:0] completed;
    logic [CNT_W-1:0] dropped_reqs;
    logic [CNT_W-1:0] orphan_resps;

    int errors = 0;
    int checks = 0;
    logic [63:0] cycleNow = 64'd0;

    // Reference model: slot table with lowest-free allocation and lowest-index match.
    typedef struct {
        bit          valid;
        logic [31:0] id;
        logic [63:0] issue;
    } model_entry_t;

    model_entry_t mTable [DEPTH];
    int          mCount;
    bit          mLatValid;
    logic [63:0] mLatLast, mLatMin, mLatMax, mLatSum;
    logic [31:0] mIdLast;
    logic [CNT_W-1:0] mCompleted, mDropped, mOrphan;

    bank_scheduler_request_latency_tracker #(
        .RANK(0), .BANK(0), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .globalCycle     (globalCycle),
        .req_fire        (req_fire),
        .req_request_id  (req_request_id),
        .req_addr        (req_addr),
        .req_is_write    (req_is_write),
        .resp_fire       (resp_fire),
        .resp_request_id (resp_request_id),
        .outstanding     (outstanding),
        .table_full      (table_full),
        .lat_valid       (lat_valid),
        .lat_last        (lat_last),
        .id_last         (id_last),
        .lat_min         (lat_min),
        .lat_max         (lat_max),
        .lat_sum         (lat_sum),
        .completed       (completed),
        .dropped_reqs    (dropped_reqs),
        .orphan_resps    (orphan_resps)
    );

    always #5 clk = ~clk;

    task automatic modelStep(input bit rstN, input bit rf, input logic [31:0] rid,
                             input bit pf, input logic [31:0] pid, input logic [63:0] cyc);
        int freeIdx;
        int matchIdx;
        logic [63:0] lat;
        logic [64:0] sumExt;
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) mTable[i].valid = 1'b0;
            mCount = 0; mLatValid = 1'b0; mLatLast = '0; mIdLast = '0;
            mLatMin = '1; mLatMax = '0; mLatSum = '0;
            mCompleted = '0; mDropped = '0; mOrphan = '0;
            return;
        end
        mLatValid = 1'b0;
        freeIdx = -1;
        matchIdx = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!mTable[i].valid && freeIdx < 0) freeIdx = i;
            if (mTable[i].valid && mTable[i].id == pid && matchIdx < 0) matchIdx = i;
        end
        if (pf) begin
            if (matchIdx >= 0) begin
                lat = cyc - mTable[matchIdx].issue;
                mTable[matchIdx].valid = 1'b0;
                mCount--;
                mLatValid = 1'b1;
                mLatLast = lat;
                mIdLast = pid;
                if (mCompleted != '1) mCompleted++;
                if (lat < mLatMin) mLatMin = lat;
                if (lat > mLatMax) mLatMax = lat;
                sumExt = {1'b0, mLatSum} + {1'b0, lat};
                mLatSum = sumExt[64] ? '1 : sumExt[63:0];
            end else if (mOrphan != '1) begin
                mOrphan++;
            end
        end
        if (rf) begin
            if (freeIdx >= 0) begin
                mTable[freeIdx].valid = 1'b1;
                mTable[freeIdx].id = rid;
                mTable[freeIdx].issue = cyc;
                mCount++;
            end else if (mDropped != '1) begin
                mDropped++;
            end
        end
    endtask

    // Drives one cycle of stimulus, advances the model at the edge, returns #1 after it.
    task automatic applyStimulus(input bit rstN, input bit rf, input logic [31:0] rid,
                                 input bit pf, input logic [31:0] pid);
        reset           = rstN;
        req_fire        = rf;
        req_request_id  = rid;
        req_addr        = $urandom;
        req_is_write    = 1'($urandom_range(0, 1));
        resp_fire       = pf;
        resp_request_id = pid;
        globalCycle     = cycleNow;
        @(posedge clk);
        modelStep(rstN, rf, rid, pf, pid, cycleNow);
        #1;
        reset     = 1'b1;
        req_fire  = 1'b0;
        resp_fire = 1'b0;
        cycleNow  = cycleNow + 64'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b1, $urandom);
        checks++; if (outstanding !== 5'd0) begin errors++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (table_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_table_full: got %0b expected 0", table_full); end
        checks++; if (lat_min !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL reset_lat_min: got %h expected all-ones", lat_min); end
        checks++; if (lat_max !== 64'd0 || lat_sum !== 64'd0 || lat_last !== 64'd0) begin errors++; $display("[TB] FAIL reset_lat: got max=%0d sum=%0d last=%0d expected 0", lat_max, lat_sum, lat_last); end
        checks++; if (completed !== '0 || dropped_reqs !== '0 || orphan_resps !== '0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", completed, dropped_reqs, orphan_resps); end
        checks++; if (lat_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_lat_valid: got %0b expected 0", lat_valid); end
    endtask

    task automatic test_single_pair();
        cycleNow = 64'd100;
        applyStimulus(1'b1, 1'b1, 32'd5, 1'b0, 32'd0);
        checks++; if (outstanding !== 5'd1) begin errors++; $display("[TB] FAIL pair_outstanding: got %0d expected 1", outstanding); end
        idle(11);
        checks++; if (lat_valid !== 1'b0) begin errors++; $display("[TB] FAIL pair_lat_valid_early: got %0b expected 0", lat_valid); end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd5);
        checks++; if (lat_valid !== 1'b1) begin errors++; $display("[TB] FAIL pair_lat_valid: got %0b expected 1", lat_valid); end
        checks++; if (lat_last !== 64'd12 || id_last !== 32'd5) begin errors++; $display("[TB] FAIL pair_last: got lat=%0d id=%0d expected 12/5", lat_last, id_last); end
        checks++; if (lat_min !== 64'd12 || lat_max !== 64'd12 || lat_sum !== 64'd12) begin errors++; $display("[TB] FAIL pair_stats: got %0d/%0d/%0d expected 12/12/12", lat_min, lat_max, lat_sum); end
        checks++; if (completed !== 32'd1 || outstanding !== 5'd0) begin errors++; $display("[TB] FAIL pair_completed: got %0d out=%0d expected 1/0", completed, outstanding); end
        idle(1);
        checks++; if (lat_valid !== 1'b0) begin errors++; $display("[TB] FAIL pair_lat_valid_pulse: got %0b expected 0", lat_valid); end
    endtask

    task automatic test_fill();
        logic [63:0] issue3;
        logic [63:0] issue18;
        applyStimulus(1'b1, 1'b1, 32'd40, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        checks++; if (outstanding !== 5'd0) begin errors++; $display("[TB] FAIL fill_midflight_reset: got %0d expected 0", outstanding); end
        issue3 = cycleNow + 64'd3;
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 32'(i), 1'b0, 32'd0);
        checks++; if (table_full !== 1'b0 || outstanding !== 5'd15) begin errors++; $display("[TB] FAIL fill_15: got full=%0b out=%0d expected 0/15", table_full, outstanding); end
        applyStimulus(1'b1, 1'b1, 32'd15, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'd16, 1'b0, 32'd0);
        checks++; if (table_full !== 1'b1 || outstanding !== 5'd16) begin errors++; $display("[TB] FAIL fill_full: got full=%0b out=%0d expected 1/16", table_full, outstanding); end
        checks++; if (dropped_reqs !== 32'd1) begin errors++; $display("[TB] FAIL fill_drop1: got %0d expected 1", dropped_reqs); end
        applyStimulus(1'b1, 1'b1, 32'd17, 1'b1, 32'd3);
        checks++; if (dropped_reqs !== 32'd2 || outstanding !== 5'd15) begin errors++; $display("[TB] FAIL fill_same_cycle: got drop=%0d out=%0d expected 2/15", dropped_reqs, outstanding); end
        checks++; if (lat_last !== cycleNow - 64'd1 - issue3 || completed !== 32'd1) begin errors++; $display("[TB] FAIL fill_resp3: got lat=%0d comp=%0d expected %0d/1", lat_last, completed, cycleNow - 64'd1 - issue3); end
        issue18 = cycleNow;
        applyStimulus(1'b1, 1'b1, 32'd18, 1'b0, 32'd0);
        checks++; if (table_full !== 1'b1 || dropped_reqs !== 32'd2) begin errors++; $display("[TB] FAIL fill_reuse: got full=%0b drop=%0d expected 1/2", table_full, dropped_reqs); end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd18);
        checks++; if (lat_last !== cycleNow - 64'd1 - issue18 || lat_last !== 64'd1 || id_last !== 32'd18) begin errors++; $display("[TB] FAIL fill_min_latency: got lat=%0d id=%0d expected 1/18", lat_last, id_last); end
    endtask

    task automatic test_orphan();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd99);
        checks++; if (orphan_resps !== 32'd1 || completed !== 32'd0) begin errors++; $display("[TB] FAIL orphan_empty: got orphan=%0d comp=%0d expected 1/0", orphan_resps, completed); end
        applyStimulus(1'b1, 1'b1, 32'd7, 1'b1, 32'd7);
        checks++; if (orphan_resps !== 32'd2 || outstanding !== 5'd1 || completed !== 32'd0) begin errors++; $display("[TB] FAIL orphan_same_cycle: got orphan=%0d out=%0d comp=%0d expected 2/1/0", orphan_resps, outstanding, completed); end
        checks++; if (lat_valid !== 1'b0) begin errors++; $display("[TB] FAIL orphan_lat_valid: got %0b expected 0", lat_valid); end
    endtask

    task automatic test_duplicates();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycleNow = 64'd10;
        applyStimulus(1'b1, 1'b1, 32'd4, 1'b0, 32'd0);
        idle(9);
        applyStimulus(1'b1, 1'b1, 32'd4, 1'b0, 32'd0);
        idle(9);
        applyStimulus(1'b1, 1'b1, 32'd2, 1'b0, 32'd0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd2);
        checks++; if (lat_last !== 64'd5 || id_last !== 32'd2) begin errors++; $display("[TB] FAIL dup_first: got lat=%0d id=%0d expected 5/2", lat_last, id_last); end
        idle(4);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd4);
        checks++; if (lat_last !== 64'd30) begin errors++; $display("[TB] FAIL dup_oldest: got %0d expected 30", lat_last); end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd4);
        checks++; if (lat_last !== 64'd21 || lat_valid !== 1'b1) begin errors++; $display("[TB] FAIL dup_second: got lat=%0d valid=%0b expected 21/1", lat_last, lat_valid); end
        checks++; if (lat_min !== 64'd5 || lat_max !== 64'd30 || lat_sum !== 64'd56) begin errors++; $display("[TB] FAIL dup_stats: got %0d/%0d/%0d expected 5/30/56", lat_min, lat_max, lat_sum); end
        checks++; if (completed !== 32'd3 || outstanding !== 5'd0) begin errors++; $display("[TB] FAIL dup_completed: got %0d out=%0d expected 3/0", completed, outstanding); end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycleNow = 64'hFFFF_FFFF_FFFF_FFFE;
        applyStimulus(1'b1, 1'b1, 32'd9, 1'b0, 32'd0);
        idle(4);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd9);
        checks++; if (lat_last !== 64'd5 || id_last !== 32'd9) begin errors++; $display("[TB] FAIL wrap_latency: got lat=%0d id=%0d expected 5/9", lat_last, id_last); end
    endtask

    task automatic test_random();
        bit rf, pf;
        logic [31:0] rid, pid;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int n = 0; n < 400; n++) begin
            rf  = ($urandom_range(0, 99) < 60);
            pf  = ($urandom_range(0, 99) < 50);
            rid = 32'($urandom_range(0, 7));
            pid = 32'($urandom_range(0, 9));
            applyStimulus(1'b1, rf, rid, pf, pid);
            checks++; if (outstanding !== 5'(mCount) || table_full !== (mCount == DEPTH)) begin errors++; $display("[TB] FAIL rand_occupancy: got out=%0d full=%0b expected %0d/%0b", outstanding, table_full, mCount, mCount == DEPTH); end
            checks++; if (lat_valid !== mLatValid || lat_last !== mLatLast || id_last !== mIdLast) begin errors++; $display("[TB] FAIL rand_last: got v=%0b lat=%0d id=%0d expected %0b/%0d/%0d", lat_valid, lat_last, id_last, mLatValid, mLatLast, mIdLast); end
            checks++; if (completed !== mCompleted || dropped_reqs !== mDropped || orphan_resps !== mOrphan) begin errors++; $display("[TB] FAIL rand_counters: got %0d/%0d/%0d expected %0d/%0d/%0d", completed, dropped_reqs, orphan_resps, mCompleted, mDropped, mOrphan); end
        end
        checks++; if (lat_min !== mLatMin || lat_max !== mLatMax || lat_sum !== mLatSum) begin errors++; $display("[TB] FAIL rand_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", lat_min, lat_max, lat_sum, mLatMin, mLatMax, mLatSum); end
    endtask

    initial begin
        reset = 1'b0; req_fire = 1'b0; resp_fire = 1'b0;
        req_request_id = '0; resp_request_id = '0; req_addr = '0; req_is_write = 1'b0;
        globalCycle = '0;
        test_reset();
        test_single_pair();
        test_fill();
        test_orphan();
        test_duplicates();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
